// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: FSM encoding, multiply latency default, counter width.
package pipe_ctrl_pkg;

  localparam int CNT_W          = 8;
  localparam int MUL_CYCLES_DEF = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  // The issue cycle and the Cnt==0 cycle both count toward the latency, hence the -2.
  function automatic cnt_t mul_load(input int cycles);
    return cnt_t'(cycles - 2);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/stall handshake bundle between the datapath (master) and pipe_ctrl (slave).
// Stall_Cnt/Flush_Cnt exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;

  logic       Ext_Hold;
  logic       Mul_Start;
  logic       Branch_Taken;
  logic       IdEx_MemRead;
  logic [4:0] IdEx_Rt;
  logic [4:0] IfId_Rs;
  logic [4:0] IfId_Rt;

  logic       En_Pc;
  logic       En_IfId;
  logic       En_IdEx;
  logic       En_ExMem;
  logic       En_MemWb;
  logic       Flush_IfId;
  logic       Flush_IdEx;
  logic       Mul_Done;
  logic       Busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] Stall_Cnt;
  logic [31:0] Flush_Cnt;
`endif

  modport master (
`ifdef PIPE_CTRL_PERF_EN
    input  Stall_Cnt, Flush_Cnt,
`endif
    output Ext_Hold, Mul_Start, Branch_Taken, IdEx_MemRead, IdEx_Rt, IfId_Rs, IfId_Rt,
    input  En_Pc, En_IfId, En_IdEx, En_ExMem, En_MemWb, Flush_IfId, Flush_IdEx, Mul_Done, Busy
  );

  modport slave (
`ifdef PIPE_CTRL_PERF_EN
    output Stall_Cnt, Flush_Cnt,
`endif
    input  Ext_Hold, Mul_Start, Branch_Taken, IdEx_MemRead, IdEx_Rt, IfId_Rs, IfId_Rt,
    output En_Pc, En_IfId, En_IdEx, En_ExMem, En_MemWb, Flush_IfId, Flush_IdEx, Mul_Done, Busy
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use compare; also instantiated by the forwarding unit.
module hazard_detect (
  input  logic       Mem_Read,
  input  logic [4:0] Dst_Rt,
  input  logic [4:0] Src_Rs,
  input  logic [4:0] Src_Rt,
  output logic       Hazard
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign Hazard = Mem_Read && (Dst_Rt != 5'd0) &&
                  ((Dst_Rt == Src_Rs) || (Dst_Rt == Src_Rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a multi-cycle multiply FSM (RUN / MUL_BUSY).
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input logic        Clk,
  input logic        Rst_N,
  pipe_ctrl_if.slave Bus
);

  logic [0:0] state;
  logic [0:0] state_nxt;
  cnt_t       cnt;
  cnt_t       cnt_nxt;
  logic       load_use;

  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic flush_ifid, flush_idex, mul_done, busy;

  hazard_detect u_hazard (
    .Mem_Read (Bus.IdEx_MemRead),
    .Dst_Rt   (Bus.IdEx_Rt),
    .Src_Rs   (Bus.IfId_Rs),
    .Src_Rt   (Bus.IfId_Rt),
    .Hazard   (load_use)
  );

  // Outputs are gated by Rst_N so the pipeline freezes the instant reset asserts.
  always_comb begin
    en_pc      = 1'b0;
    en_ifid    = 1'b0;
    en_idex    = 1'b0;
    en_exmem   = 1'b0;
    en_memwb   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    mul_done   = 1'b0;
    busy       = 1'b0;
    if (Rst_N) begin
      if (state == ST_RUN) begin
        if (Bus.Ext_Hold) begin
          en_pc = 1'b0;
        end else if (Bus.Mul_Start) begin
          en_memwb = 1'b1;
        end else if (Bus.Branch_Taken) begin
          {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (load_use) begin
          {en_idex, en_exmem, en_memwb} = 3'b111;
          flush_idex = 1'b1;
        end else begin
          {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
        end
      end else begin
        busy = 1'b1;
        if (cnt != '0) begin
          en_memwb = ~Bus.Ext_Hold;
        end else begin
          mul_done = 1'b1;
          {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = {5{~Bus.Ext_Hold}};
        end
      end
    end
  end

  // The multiply counter keeps running under Ext_Hold so latency stays fixed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_RUN) begin
      if (!Bus.Ext_Hold && Bus.Mul_Start) begin
        state_nxt = ST_MUL_BUSY;
        cnt_nxt   = mul_load(MUL_CYCLES);
      end
    end else if (cnt == '0) begin
      state_nxt = ST_RUN;
    end else begin
      cnt_nxt = cnt - cnt_t'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign Bus.En_Pc      = en_pc;
  assign Bus.En_IfId    = en_ifid;
  assign Bus.En_IdEx    = en_idex;
  assign Bus.En_ExMem   = en_exmem;
  assign Bus.En_MemWb   = en_memwb;
  assign Bus.Flush_IfId = flush_ifid;
  assign Bus.Flush_IdEx = flush_idex;
  assign Bus.Mul_Done   = mul_done;
  assign Bus.Busy       = busy;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en_pc) stall_cnt <= stall_cnt + 32'd1;
      if (flush_ifid) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign Bus.Stall_Cnt = stall_cnt;
  assign Bus.Flush_Cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int MUL_CYCLES = 32;

  logic Clk = 1'b0;
  logic Rst_N;

  pipe_ctrl_if Bus ();

  pipe_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .Bus   (Bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: number of multiply-busy cycles still to come, including the current one.
  int          busyLeft = 0;
  int unsigned mStall   = 0;
  int unsigned mFlush   = 0;
  logic [8:0]  lastObs;

  // Bit order: En_Pc En_IfId En_IdEx En_ExMem En_MemWb Flush_IfId Flush_IdEx Mul_Done Busy
  function automatic logic [8:0] observe();
    return {Bus.En_Pc, Bus.En_IfId, Bus.En_IdEx, Bus.En_ExMem, Bus.En_MemWb,
            Bus.Flush_IfId, Bus.Flush_IdEx, Bus.Mul_Done, Bus.Busy};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic hold, input logic mul,
                               input logic br, input logic mr, input logic [4:0] exRt,
                               input logic [4:0] rs, input logic [4:0] rt);
    logic [8:0] exp;
    logic       loadUse;
    @(negedge Clk);
    Bus.Ext_Hold     = hold;
    Bus.Mul_Start    = mul;
    Bus.Branch_Taken = br;
    Bus.IdEx_MemRead = mr;
    Bus.IdEx_Rt      = exRt;
    Bus.IfId_Rs      = rs;
    Bus.IfId_Rt      = rt;
    #1;
    loadUse = mr && (exRt != 5'd0) && ((exRt == rs) || (exRt == rt));
    if (busyLeft == 0) begin
      if (hold)         exp = 9'b00000_00_0_0;
      else if (mul)     exp = 9'b00001_00_0_0;
      else if (br)      exp = 9'b11111_11_0_0;
      else if (loadUse) exp = 9'b00111_01_0_0;
      else              exp = 9'b11111_00_0_0;
    end else if (busyLeft == 1) begin
      exp = {{5{!hold}}, 2'b00, 1'b1, 1'b1};
    end else begin
      exp = {4'b0000, !hold, 2'b00, 1'b0, 1'b1};
    end
    lastObs = observe();
    checkOutput(tag, 32'(lastObs), 32'(exp));
`ifdef PIPE_CTRL_PERF_EN
    checkOutput({tag, "_stallcnt"}, Bus.Stall_Cnt, mStall);
    checkOutput({tag, "_flushcnt"}, Bus.Flush_Cnt, mFlush);
`endif
    if (!exp[8]) mStall++;
    if (exp[3])  mFlush++;
    if (busyLeft == 0) begin
      if (!hold && mul) busyLeft = MUL_CYCLES - 1;
    end else begin
      busyLeft--;
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous freeze, releases on the next negedge.
  task automatic applyReset(input string tag);
    #1;
    Rst_N = 1'b0;
    #1;
    checkOutput(tag, 32'(observe()), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput({tag, "_stallcnt"}, Bus.Stall_Cnt, 32'd0);
    checkOutput({tag, "_flushcnt"}, Bus.Flush_Cnt, 32'd0);
`endif
    busyLeft = 0;
    mStall   = 0;
    mFlush   = 0;
    Bus.Ext_Hold     = 1'b0;
    Bus.Mul_Start    = 1'b0;
    Bus.Branch_Taken = 1'b0;
    Bus.IdEx_MemRead = 1'b0;
    Bus.IdEx_Rt      = 5'd0;
    Bus.IfId_Rs      = 5'd0;
    Bus.IfId_Rt      = 5'd0;
    @(negedge Clk);
    Rst_N = 1'b1;
    #1;
    checkOutput({tag, "_release"}, 32'(observe()), 32'(9'b11111_00_0_0));
  endtask

  initial begin
    int busyCycles;
    int doneAt;
    logic doneEnPc;
    logic memWbDuringHold;

    Rst_N = 1'b0;
    applyReset("reset");

    applyStimulus("normal0", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus("loaduse_rs", 0, 0, 0, 1, 5'd5, 5'd5, 5'd0);
    applyStimulus("loaduse_clear", 0, 0, 0, 0, 5'd5, 5'd5, 5'd0);
    applyStimulus("loaduse_r0", 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    applyStimulus("loaduse_rt", 0, 0, 0, 1, 5'd7, 5'd3, 5'd7);
    applyStimulus("loaduse_miss", 0, 0, 0, 1, 5'd7, 5'd3, 5'd4);
    applyStimulus("branch_lu", 0, 0, 1, 1, 5'd5, 5'd5, 5'd0);
    applyStimulus("hold_all", 1, 1, 1, 1, 5'd5, 5'd5, 5'd5);
    applyStimulus("after_hold", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

    // Plain multiply; Mul_Start and hazards during busy must be ignored.
    applyStimulus("mul_issue", 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    busyCycles = 0;
    doneAt     = 0;
    doneEnPc   = 1'b0;
    for (int i = 1; i <= MUL_CYCLES - 1; i++) begin
      applyStimulus("mul_busy", 0, 1'(i % 2), 1'(i % 3 == 0), 1, 5'd5, 5'd5, 5'd5);
      if (lastObs[0]) busyCycles++;
      if (lastObs[1]) begin
        doneAt   = i;
        doneEnPc = lastObs[8];
      end
    end
    checkOutput("mul_busy_len", busyCycles, MUL_CYCLES - 1);
    checkOutput("mul_done_at", doneAt, MUL_CYCLES - 1);
    checkOutput("mul_done_enpc", 32'(doneEnPc), 32'd1);
    applyStimulus("mul_after", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

    // Hold for five cycles inside the multiply: latency unchanged, MemWb frozen.
    applyStimulus("mulh_issue", 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    doneAt          = 0;
    memWbDuringHold = 1'b0;
    for (int i = 1; i <= MUL_CYCLES - 1; i++) begin
      applyStimulus("mulh_busy", (i >= 10 && i < 15), 0, 0, 0, 5'd0, 5'd0, 5'd0);
      if (i >= 10 && i < 15) memWbDuringHold = memWbDuringHold | lastObs[4];
      if (lastObs[1]) doneAt = i;
    end
    checkOutput("mulh_done_at", doneAt, MUL_CYCLES - 1);
    checkOutput("mulh_memwb_hold", 32'(memWbDuringHold), 32'd0);

    // Hold on the final busy cycle still returns to RUN.
    applyStimulus("mulx_issue", 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= MUL_CYCLES - 1; i++)
      applyStimulus("mulx_busy", (i == MUL_CYCLES - 1), 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus("mulx_after", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

    // Reset during busy cycle 10 aborts the multiply.
    applyStimulus("mulr_issue", 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 10; i++)
      applyStimulus("mulr_busy", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyReset("reset_mid_mul");
    applyStimulus("mulr_resume", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

`ifdef PIPE_CTRL_PERF_EN
    applyReset("perf_reset");
    applyStimulus("perf_mul", 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= MUL_CYCLES - 1; i++)
      applyStimulus("perf_busy", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus("perf_lu", 0, 0, 0, 1, 5'd5, 5'd5, 5'd0);
    applyStimulus("perf_end", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    checkOutput("perf_stall_total", Bus.Stall_Cnt, 32'd32);
    checkOutput("perf_flush_total", Bus.Flush_Cnt, 32'd0);
`endif

    // Randomized traffic with small register numbers so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 99) < 15),
                    ($urandom_range(0, 99) < 6),
                    ($urandom_range(0, 99) < 15),
                    ($urandom_range(0, 99) < 50),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
